alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Operand-issue and result-capture stage wrapped around the 32-bit multi-function ALU. It buffers incoming {op, A, B} commands in a small FIFO and drives registered operands into the combinational ALU. It captures F, overflow and zero into a result register and presents them downstream with a valid/ready handshake. This gives the ALU a clean, backpressure-aware pipeline boundary on both sides.

## Interface
- DEPTH, 4, command FIFO depth in entries (power of two, ≥2)
- ALU_ISSUE_clk_xi  in  1  clock; all state updates on the rising edge
- ALU_ISSUE_rst_xi  in  1  reset; asynchronous, active-high
- ALU_ISSUE_cmd_valid_xi  in  1  command present
- ALU_ISSUE_cmd_ready_xo  out  1  stage can accept a command (= FIFO not full)
- ALU_ISSUE_cmd_op_xi  in  3  ALU opcode: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT (unsigned), 111 SLL (B << A)
- ALU_ISSUE_cmd_a_xi / ALU_ISSUE_cmd_b_xi  in  32  operands
- ALU_ISSUE_cmd_fwd_xi  in  1  use last result as A (present only with ALU_ISSUE_FWD_EN)
- ALU_ISSUE_alu_a_xo / ALU_ISSUE_alu_b_xo  out  32  registered operands to ALU
- ALU_ISSUE_alu_op_xo  out  3  registered opcode to ALU
- ALU_ISSUE_alu_f_xi  in  32  ALU result
- ALU_ISSUE_alu_ovf_xi  in  1  ALU carry/borrow bit
- ALU_ISSUE_res_valid_xo  out  1  result register holds an unconsumed result
- ALU_ISSUE_res_ready_xi  in  1  downstream accepts result
- ALU_ISSUE_res_f_xo  out  32  captured result
- ALU_ISSUE_res_ovf_xo  out  1  captured overflow (ADD/SUB only, else 0)
- ALU_ISSUE_res_zero_xo  out  1  captured (res_f == 0)
- ALU_ISSUE_level_xo  out  log2(DEPTH)+1  FIFO occupancy

## Operation
- Push: cmd_valid && cmd_ready writes {op, a, b[, fwd]} into the FIFO. No push while full. Push and pop in the same cycle leave the level unchanged.
- FSM states: IDLE, EXEC, HOLD.
- IDLE: if FIFO non-empty, pop into the operand registers and go to EXEC; else stay.
- EXEC: the ALU settles on the registered operands. At the end of the cycle, capture alu_f_xi into res_f and compute res_zero from alu_f_xi. Set res_ovf = alu_ovf_xi for op 100/101, otherwise 0. Set res_valid=1 and go to HOLD.
- HOLD: res_valid=1 and the outputs are stable. When res_ready is asserted, clear res_valid. Then, if the FIFO is non-empty, pop the next entry into the operands (→ EXEC); else go to IDLE. If res_ready is low, stay; commands keep filling the FIFO.
- Operand registers hold their last value in IDLE and HOLD; the ALU inputs never glitch to X.
- res_f retains its value after consumption (forwarding source).
- Overflow is the raw 33rd bit of the unsigned sum/difference (carry / borrow). It is not a signed overflow.

## Timing
- Reset values: cmd_ready=1, level=0, alu_a/alu_b=0, alu_op=000, res_valid=0, res_f=0, res_ovf=0, res_zero=0, state=IDLE.
- Latency:
  - Command accepted at edge k from an empty, idle stage → popped at edge k+1 → res_valid high after edge k+2.
  - Throughput is one result per 2 cycles with res_ready held high.
- cmd_ready depends only on registered level, not combinationally on res_ready.
- The FIFO pointers wrap modulo DEPTH. level reaches DEPTH exactly when full.
- Reset asserted mid-operation: FIFO contents, in-flight operands and any pending result are discarded immediately; all outputs take reset values asynchronously.

## Configuration
- ALU_ISSUE_FWD_EN defined:
  - The cmd_fwd_xi port exists and is stored per FIFO entry.
  - On pop with fwd=1, alu_a is loaded from the current res_f (0 after reset) instead of the stored A.
  - The pop in HOLD happens in the same edge that consumes the result, so the forwarded value is the result being consumed.
- ALU_ISSUE_FWD_EN undefined: the port and FIFO bit are absent, and A always comes from the command.

## Structure
- Package alu_issue_pkg holds:
  - the FSM state enum (IDLE/EXEC/HOLD);
  - opcode localparams ALU_OP_AND…ALU_OP_SLL;
  - the command entry struct/width constant.
- Sub-module alu_issue_fifo: parameterised DEPTH × entry-width synchronous FIFO with full/empty/level and asynchronous active-high reset.

## Test plan
- Reset: assert rst mid-stream → cmd_ready=1, res_valid=0, level=0, res_f=0 immediately; a result pending before reset is never presented.
- ADD A=0xFFFFFFFF B=0x00000001, res_ready=1 → res_valid 2 cycles after accept, res_f=0, res_ovf=1, res_zero=1.
- SLT A=3 B=5 → res_f=1, ovf=0, zero=0. SLL A=4 B=0x1 → res_f=0x10. XOR A=B=0xA5A5A5A5 → res_f=0, zero=1, ovf=0.
- Backpressure with DEPTH=4, res_ready=0: offer 7 commands → exactly 5 accepted (1 in the result register, 4 in the FIFO), cmd_ready=0, level=4. Then hold res_ready=1 → 5 results in order, one per 2 cycles.
- Forwarding (FWD_EN): ADD 2+3, then AND fwd=1 B=0x4 → results 5 then 4. Without the macro, the same second command with A=0 gives 0.
- SUB A=0 B=1 → res_f=0xFFFFFFFF, res_ovf=1. Then OR A=0 B=0 → res_ovf=0, zero=1 (overflow not sticky).

Source files
------------

// File: rtl/alu_issue_pkg.sv
// ============================================================================
// Module      : alu_issue_pkg
// Description : Shared types for the ALU issue stage: FSM states, opcodes and
//               the FIFO command entry. The entry carries a forwarding bit
//               only when ALU_ISSUE_FWD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_issue_pkg;

    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_XOR = 3'b010;
    localparam logic [2:0] ALU_OP_NOR = 3'b011;
    localparam logic [2:0] ALU_OP_ADD = 3'b100;
    localparam logic [2:0] ALU_OP_SUB = 3'b101;
    localparam logic [2:0] ALU_OP_SLT = 3'b110;
    localparam logic [2:0] ALU_OP_SLL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef struct packed {
`ifdef ALU_ISSUE_FWD_EN
        logic        fwd;
`endif
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Only the arithmetic ops expose the ALU carry/borrow bit.
    function automatic logic op_has_carry(input logic [2:0] op);
        return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_fifo.sv
// ============================================================================
// Module      : alu_issue_fifo
// Description : DEPTH x WIDTH synchronous FIFO with full/empty/level flags,
//               asynchronous active-high reset, pointers wrap modulo DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (level_q == (AW+1)'(DEPTH));
    assign o_empty = (level_q == '0);
    assign o_level = level_q;
    assign o_rdata = mem_q[rd_ptr_q];

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: a zero level makes stale entries unreachable.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module      : alu_issue_stage
// Description : Command FIFO + registered operand issue + result capture with
//               valid/ready handshake around an external combinational ALU.
//               Define ALU_ISSUE_FWD_EN to enable result forwarding into A.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    ALU_ISSUE_clk_xi,
    input  logic                    ALU_ISSUE_rst_xi,
    input  logic                    ALU_ISSUE_cmd_valid_xi,
    output logic                    ALU_ISSUE_cmd_ready_xo,
    input  logic [2:0]              ALU_ISSUE_cmd_op_xi,
    input  logic [31:0]             ALU_ISSUE_cmd_a_xi,
    input  logic [31:0]             ALU_ISSUE_cmd_b_xi,
`ifdef ALU_ISSUE_FWD_EN
    input  logic                    ALU_ISSUE_cmd_fwd_xi,
`endif
    output logic [31:0]             ALU_ISSUE_alu_a_xo,
    output logic [31:0]             ALU_ISSUE_alu_b_xo,
    output logic [2:0]              ALU_ISSUE_alu_op_xo,
    input  logic [31:0]             ALU_ISSUE_alu_f_xi,
    input  logic                    ALU_ISSUE_alu_ovf_xi,
    output logic                    ALU_ISSUE_res_valid_xo,
    input  logic                    ALU_ISSUE_res_ready_xi,
    output logic [31:0]             ALU_ISSUE_res_f_xo,
    output logic                    ALU_ISSUE_res_ovf_xo,
    output logic                    ALU_ISSUE_res_zero_xo,
    output logic [$clog2(DEPTH):0]  ALU_ISSUE_level_xo
);

    state_t      state_q, state_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic        res_valid_q, res_valid_d;
    logic [31:0] res_f_q, res_f_d;
    logic        res_ovf_q, res_ovf_d;
    logic        res_zero_q, res_zero_d;

    cmd_t        push_entry;
    cmd_t        pop_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        fifo_push;
    logic [31:0] pop_a;

    always_comb begin
        push_entry.op = ALU_ISSUE_cmd_op_xi;
        push_entry.a  = ALU_ISSUE_cmd_a_xi;
        push_entry.b  = ALU_ISSUE_cmd_b_xi;
`ifdef ALU_ISSUE_FWD_EN
        push_entry.fwd = ALU_ISSUE_cmd_fwd_xi;
`endif
    end

    assign fifo_push = ALU_ISSUE_cmd_valid_xi;

    alu_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .i_clk   (ALU_ISSUE_clk_xi),
        .i_rst   (ALU_ISSUE_rst_xi),
        .i_push  (fifo_push),
        .i_wdata (push_entry),
        .i_pop   (fifo_pop),
        .o_rdata (pop_entry),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_level (ALU_ISSUE_level_xo)
    );

    // res_f_q is still the result being consumed when a HOLD pop forwards it.
    always_comb begin
        pop_a = pop_entry.a;
`ifdef ALU_ISSUE_FWD_EN
        if (pop_entry.fwd) begin
            pop_a = res_f_q;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_valid_d = res_valid_q;
        res_f_d     = res_f_q;
        res_ovf_d   = res_ovf_q;
        res_zero_d  = res_zero_q;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    alu_a_d  = pop_a;
                    alu_b_d  = pop_entry.b;
                    alu_op_d = pop_entry.op;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_f_d     = ALU_ISSUE_alu_f_xi;
                res_zero_d  = (ALU_ISSUE_alu_f_xi == 32'd0);
                res_ovf_d   = op_has_carry(alu_op_q) && ALU_ISSUE_alu_ovf_xi;
                res_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (ALU_ISSUE_res_ready_xi) begin
                    res_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        alu_a_d  = pop_a;
                        alu_b_d  = pop_entry.b;
                        alu_op_d = pop_entry.op;
                        state_d  = ST_EXEC;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ALU_ISSUE_clk_xi or posedge ALU_ISSUE_rst_xi) begin
        if (ALU_ISSUE_rst_xi) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= ALU_OP_AND;
            res_valid_q <= 1'b0;
            res_f_q     <= '0;
            res_ovf_q   <= 1'b0;
            res_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_valid_q <= res_valid_d;
            res_f_q     <= res_f_d;
            res_ovf_q   <= res_ovf_d;
            res_zero_q  <= res_zero_d;
        end
    end

    assign ALU_ISSUE_cmd_ready_xo = !fifo_full;
    assign ALU_ISSUE_alu_a_xo     = alu_a_q;
    assign ALU_ISSUE_alu_b_xo     = alu_b_q;
    assign ALU_ISSUE_alu_op_xo    = alu_op_q;
    assign ALU_ISSUE_res_valid_xo = res_valid_q;
    assign ALU_ISSUE_res_f_xo     = res_f_q;
    assign ALU_ISSUE_res_ovf_xo   = res_ovf_q;
    assign ALU_ISSUE_res_zero_xo  = res_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Randomised scoreboard bench for alu_issue_stage with a
//               behavioural ALU; honours ALU_ISSUE_FWD_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [31:0]   cmd_a, cmd_b;
`ifdef ALU_ISSUE_FWD_EN
    logic          cmd_fwd;
`endif
    logic [31:0]   alu_a, alu_b, alu_f;
    logic [2:0]    alu_op;
    logic          alu_ovf;
    logic          res_valid, res_ready;
    logic [31:0]   res_f;
    logic          res_ovf, res_zero;
    logic [LW-1:0] level;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] f;
        logic        ovf;
        logic        zero;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] last_f = 32'd0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DEPTH(DEPTH)) dut (
        .ALU_ISSUE_clk_xi       (clk),
        .ALU_ISSUE_rst_xi       (rst),
        .ALU_ISSUE_cmd_valid_xi (cmd_valid),
        .ALU_ISSUE_cmd_ready_xo (cmd_ready),
        .ALU_ISSUE_cmd_op_xi    (cmd_op),
        .ALU_ISSUE_cmd_a_xi     (cmd_a),
        .ALU_ISSUE_cmd_b_xi     (cmd_b),
`ifdef ALU_ISSUE_FWD_EN
        .ALU_ISSUE_cmd_fwd_xi   (cmd_fwd),
`endif
        .ALU_ISSUE_alu_a_xo     (alu_a),
        .ALU_ISSUE_alu_b_xo     (alu_b),
        .ALU_ISSUE_alu_op_xo    (alu_op),
        .ALU_ISSUE_alu_f_xi     (alu_f),
        .ALU_ISSUE_alu_ovf_xi   (alu_ovf),
        .ALU_ISSUE_res_valid_xo (res_valid),
        .ALU_ISSUE_res_ready_xi (res_ready),
        .ALU_ISSUE_res_f_xo     (res_f),
        .ALU_ISSUE_res_ovf_xo   (res_ovf),
        .ALU_ISSUE_res_zero_xo  (res_zero),
        .ALU_ISSUE_level_xo     (level)
    );

    function automatic logic [31:0] ref_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a | b);
            3'd4:    return a + b;
            3'd5:    return a - b;
            3'd6:    return (a < b) ? 32'd1 : 32'd0;
            default: return (a > 32'd31) ? 32'd0 : (b << a);
        endcase
    endfunction

    // Raw 33rd bit; the ALU model deliberately emits it for every opcode.
    function automatic logic ref_carry(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        if (op == 3'd5) s = {1'b0, a} - {1'b0, b};
        else            s = {1'b0, a} + {1'b0, b};
        return s[32];
    endfunction

    assign alu_f   = ref_f(alu_op, alu_a, alu_b);
    assign alu_ovf = ref_carry(alu_op, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
        end
    endtask

    task automatic push_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic fwd);
        exp_t        e;
        logic [31:0] a_eff;
        a_eff  = (FWD && fwd) ? last_f : a;
        e.f    = ref_f(op, a_eff, b);
        e.ovf  = (op == 3'd4 || op == 3'd5) ? ref_carry(op, a_eff, b) : 1'b0;
        e.zero = (e.f == 32'd0);
        exp_q.push_back(e);
        last_f = e.f;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 40));
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic fwd);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
`ifdef ALU_ISSUE_FWD_EN
        cmd_fwd   = fwd;
`endif
        while (!cmd_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got cmd_ready=0, want 1 within 1000 cycles");
        end else begin
            push_exp(op, a, b, fwd);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        res_ready = 1'b1;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Scoreboard monitor: samples late in the low phase, well clear of both edges.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got res_f=0x%08h, want no result", res_f);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_f", res_f, e.f);
                    chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
                    chk("res_zero", 32'(res_zero), 32'(e.zero));
                end
            end
        end
    end

    initial begin
        int  accepted;
        bit  done;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = 32'd0;
        cmd_b     = 32'd0;
`ifdef ALU_ISSUE_FWD_EN
        cmd_fwd   = 1'b0;
`endif
        res_ready = 1'b0;

        #1 rst = 1'b1;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_f", res_f, 32'd0);
        chk("rst_res_ovf", 32'(res_ovf), 32'd0);
        chk("rst_res_zero", 32'(res_zero), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);

        // Latency from an idle, empty stage.
        send(ALU_OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0);
        chk("lat_k0_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("lat_k1_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("lat_k2_valid", 32'(res_valid), 32'd1);

        send(ALU_OP_SLT, 32'd3, 32'd5, 1'b0);
        send(ALU_OP_SLL, 32'd4, 32'h1, 1'b0);
        send(ALU_OP_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
        send(ALU_OP_SUB, 32'd0, 32'd1, 1'b0);
        send(ALU_OP_OR, 32'd0, 32'd0, 1'b0);
        send(ALU_OP_NOR, 32'h0F0F_0000, 32'h0000_F0F0, 1'b0);
        send(ALU_OP_ADD, 32'd2, 32'd3, 1'b0);
        send(ALU_OP_AND, 32'd0, 32'h4, 1'b1);
        drain();

        // Backpressure: one result held, FIFO fills to DEPTH.
        res_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 7; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_a     = rnd_operand();
            cmd_b     = rnd_operand();
            if (cmd_ready) begin
                push_exp(cmd_op, cmd_a, cmd_b, 1'b0);
                accepted++;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("bp_accepted", 32'(accepted), 32'd5);
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("bp_level", 32'(level), 32'(DEPTH));
        chk("bp_res_valid", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_valid_%0d", i), 32'(res_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        chk("bp_drained", 32'(exp_q.size()), 32'd0);
        drain();

        // Random traffic with random downstream backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    res_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                end
            end
        join
        drain();

        // Reset while a result is pending and commands are queued.
        res_ready = 1'b0;
        send(ALU_OP_ADD, 32'd1, 32'd1, 1'b0);
        send(ALU_OP_OR, 32'd7, 32'd0, 1'b0);
        send(ALU_OP_XOR, 32'd9, 32'd3, 1'b0);
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", 32'(res_valid), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_res_f", res_f, 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        exp_q.delete();
        last_f = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_valid_%0d", i), 32'(res_valid), 32'd0);
        end
        send(ALU_OP_OR, 32'h5, 32'h30, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, want finish before 500000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
